load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store sequencer between the control unit/ALU and DataMemory.
//  Computes the effective byte address (base + sign-extended offset) and drives
//  DataMemory's data_address/write_en/write_data. Latches read_data into a
//  memory data register. Supports byte/half/word access; sub-word stores use a
//  read-modify-write.
// PARAMETERS
//  DATA_W   32  data width (fixed; byte-lane logic assumes 32)
//  ADDR_W   16  DataMemory word-address width; word addr = ea[ADDR_W+1:2]
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   synchronous active-low reset
//  start         in   1   request; sampled only in IDLE
//  is_store      in   1   1 = store, 0 = load
//  size          in   2   00 byte, 01 half, 10 word, 11 reserved (treated as error)
//  sign_ext      in   1   loads: 1 sign-extend, 0 zero-extend
//  base          in   32  base register value
//  offset        in   16  signed byte offset
//  store_data    in   32  store source; sub-word data in low bits
//  read_data     in   32  from DataMemory (combinational read)
//  data_address  out  16  to DataMemory, word address (registered)
//  write_en      out  1   to DataMemory (registered)
//  write_data    out  32  to DataMemory (registered)
//  load_data     out  32  extended load result (MDR)
//  busy          out  1   high from the cycle after start until done
//  done          out  1   one-cycle completion pulse
//  err           out  1   valid with done; misaligned/out-of-range/reserved size
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE. Reset mid-operation aborts on that edge.
//   write_en is 0 after the edge; no later write occurs; load_data is cleared.
//  FSM: IDLE, ADDR, READ, WRITE, DONE.
//  - IDLE: on start=1, latch is_store/size/sign_ext/base/offset/store_data -> ADDR.
//    start while busy is ignored (not queued).
//  - ADDR: ea = base + sext(offset), 32-bit wrap. Register ea.
//    data_address <= ea[17:2]. Check for an error:
//    (half & ea[0]) | (word & ea[1:0]!=0) | ea[31:18]!=0 | size==11.
//    On error -> DONE, err=1. Else load or sub-word store -> READ; word store -> WRITE.
//  - READ: sample read_data at end of cycle.
//    Load: extract lane -> load_data -> DONE.
//    Sub-word store: merge store_data lane into read word -> write_data -> WRITE.
//  - WRITE: write_en=1 for exactly this cycle; data_address/write_data stable -> DONE.
//    Word store: write_data = store_data (set on ADDR exit).
//  - DONE: done=1, busy=0 next edge -> IDLE. err clears when next op enters ADDR.
//  Lanes are little-endian: byte k = bits[8k+7:8k], k=ea[1:0]. Half = ea[1].
//  Extension: sign_ext replicates the lane MSB; otherwise zero-fill.
//  Latency (start edge -> done high): load 3, word store 3, sub-word store 4, error 2.
//  Back-to-back: start may assert in the cycle done is high. It is accepted
//   on the following IDLE cycle, not during DONE.
//  write_en never asserts on error or in any state except WRITE.
//  load_data changes only on a successful load.
// TESTING
//  1 Word store base=0x0, off=0x000C, data=0x88442211; then word load ->
//    write_en pulses once, addr=3; load_data=0x88442211; done at +3, err=0.
//  2 Byte load ea=0xD, sign_ext=1 -> load_data=0xFFFFFF88... expect lane1=0x22 ->
//    0x00000022; ea=0xF sign_ext=1 -> 0xFFFFFF88; sign_ext=0 -> 0x00000088.
//  3 Half store data=0xBEEF at ea=0xE -> read-modify-write to word 3 = 0xBEEF2211;
//    done at +4; a later half load at ea=0xE, sign_ext=1 -> 0xFFFFBEEF.
//  4 Misaligned: word load ea=0x6, half store ea=0x5, base=0x00040000 ->
//    err=1 with done at +2, write_en never high, load_data unchanged.
//  5 Reset mid-op: assert rst_n=0 in the WRITE cycle of a store, or start+1 ->
//    memory word unchanged, all outputs 0, next start completes normally.
//  6 Negative offset base=0x20, off=0xFFF8 -> addr=6; start held high during busy
//    -> only one op per IDLE entry.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store sequencer sitting between the
// control unit and DataMemory. Forms the effective byte address, checks it,
// then performs a load, a word store, or a read-modify-write sub-word store.
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       base,
  input  logic [15:0]       offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] data_address,
  output logic              write_en,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t              state_q, state_d;
  logic                is_store_q, is_store_d;
  logic [1:0]          size_q, size_d;
  logic                sign_ext_q, sign_ext_d;
  logic [31:0]         base_q, base_d;
  logic [15:0]         offset_q, offset_d;
  logic [DATA_W-1:0]   store_data_q, store_data_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   data_address_q, data_address_d;
  logic                write_en_q, write_en_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                err_q, err_d;

  // Datapath helpers
  logic [31:0]         ea_calc;
  logic                addr_err;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;

  // Effective address and the legality check on it
  always_comb begin
    ea_calc  = base_q + {{16{offset_q[15]}}, offset_q};
    addr_err = (size_q == SZ_RSVD)
             | ((size_q == SZ_HALF) & ea_calc[0])
             | ((size_q == SZ_WORD) & (ea_calc[1:0] != 2'b00))
             | (|ea_calc[31:ADDR_W+2]);
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    byte_lane = read_data[{lane_q, 3'b000} +: 8];
    half_lane = read_data[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_ext = {{(DATA_W-8){sign_ext_q & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_ext = {{(DATA_W-16){sign_ext_q & half_lane[15]}}, half_lane};
      default: load_ext = read_data;
    endcase
    merged = read_data;
    if (size_q == SZ_BYTE) begin
      merged[{lane_q, 3'b000} +: 8] = store_data_q[7:0];
    end else if (size_q == SZ_HALF) begin
      merged[{lane_q[1], 4'b0000} +: 16] = store_data_q[15:0];
    end
  end

  // Next-state and register-update logic for the sequencer
  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    size_d         = size_q;
    sign_ext_d     = sign_ext_q;
    base_d         = base_q;
    offset_d       = offset_q;
    store_data_d   = store_data_q;
    lane_d         = lane_q;
    data_address_d = data_address_q;
    write_data_d   = write_data_q;
    load_data_d    = load_data_q;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d   = is_store;
          size_d       = size;
          sign_ext_d   = sign_ext;
          base_d       = base;
          offset_d     = offset;
          store_data_d = store_data;
          err_d        = 1'b0;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        lane_d         = ea_calc[1:0];
        data_address_d = ea_calc[ADDR_W+1:2];
        if (addr_err) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (is_store_q && (size_q == SZ_WORD)) begin
          write_data_d = store_data_q;
          state_d      = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (is_store_q) begin
          write_data_d = merged;
          state_d      = S_WRITE;
        end else begin
          load_data_d = load_ext;
          state_d     = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobe is registered so it is high exactly while in WRITE
    write_en_d = (state_d == S_WRITE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      is_store_q     <= 1'b0;
      size_q         <= 2'b00;
      sign_ext_q     <= 1'b0;
      base_q         <= '0;
      offset_q       <= '0;
      store_data_q   <= '0;
      lane_q         <= 2'b00;
      data_address_q <= '0;
      write_en_q     <= 1'b0;
      write_data_q   <= '0;
      load_data_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_store_q     <= is_store_d;
      size_q         <= size_d;
      sign_ext_q     <= sign_ext_d;
      base_q         <= base_d;
      offset_q       <= offset_d;
      store_data_q   <= store_data_d;
      lane_q         <= lane_d;
      data_address_q <= data_address_d;
      write_en_q     <= write_en_d;
      write_data_q   <= write_data_d;
      load_data_q    <= load_data_d;
      err_q          <= err_d;
    end
  end

  // Outputs; the strobe is qualified by rst_n so a reset asserted during
  // the WRITE cycle also suppresses the memory write on that same edge.
  assign data_address = data_address_q;
  assign write_en     = write_en_q & rst_n;
  assign write_data   = write_data_q;
  assign load_data    = load_data_q;
  assign err          = err_q;
  assign done         = (state_q == S_DONE);
  assign busy         = (state_q == S_ADDR) || (state_q == S_READ) || (state_q == S_WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural memory, reference model of the
// load/store rules, directed cases followed by randomized operations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic [31:0] read_data;
  logic [15:0] data_address;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned n_writes = 0;

  bit [31:0]   dut_mem [0:65535];
  bit [31:0]   ref_mem [0:65535];
  logic [31:0] exp_load = 32'h0;

  load_store_unit #(.DATA_W(32), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .base(base), .offset(offset),
    .store_data(store_data), .read_data(read_data),
    .data_address(data_address), .write_en(write_en), .write_data(write_data),
    .load_data(load_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // DataMemory stand-in: combinational read, synchronous write
  assign read_data = dut_mem[data_address];
  always @(posedge clk) begin
    if (write_en === 1'b1) begin
      dut_mem[data_address] <= write_data;
      n_writes <= n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".write_en"}, {31'b0, write_en}, 32'h0);
    check({tag, ".done"}, {31'b0, done}, 32'h0);
    check({tag, ".busy"}, {31'b0, busy}, 32'h0);
    check({tag, ".err"}, {31'b0, err}, 32'h0);
    check({tag, ".load_data"}, load_data, 32'h0);
    check({tag, ".addr"}, {16'h0, data_address}, 32'h0);
    check({tag, ".wdata"}, write_data, 32'h0);
  endtask

  // Issue one operation and check it against the reference rules.
  // b2b: assert start during the current (done) cycle instead of waiting.
  // hold: keep start high for the whole busy period.
  task automatic run_op(input string tag, input bit st, input logic [1:0] sz, input bit sx,
                        input logic [31:0] b, input logic [15:0] o, input logic [31:0] d,
                        input bit b2b, input bit hold);
    logic [31:0] ea, old, nw, v;
    logic [15:0] widx;
    bit          er;
    int          lat, cyc, sh;
    int unsigned w0;

    ea   = b + {{16{o[15]}}, o};
    er   = (sz == 2'b11) || (sz == 2'b01 && ea[0]) || (sz == 2'b10 && ea[1:0] != 2'b00)
           || (ea[31:18] != 14'h0);
    widx = ea[17:2];
    lat  = er ? 2 : (!st ? 3 : ((sz == 2'b10) ? 3 : 4));

    if (!b2b) @(negedge clk);
    w0 = n_writes;
    start = 1'b1; is_store = st; size = sz; sign_ext = sx;
    base = b; offset = o; store_data = d;
    if (b2b) begin
      @(negedge clk);
      check({tag, ".ignored_in_done"}, {31'b0, busy}, 32'h0);
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, ".busy"}, {31'b0, busy}, 32'h1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end

    // Reference model
    if (!er) begin
      old = ref_mem[widx];
      if (sz == 2'b10) sh = 0;
      else if (sz == 2'b01) sh = 16 * int'(ea[1]);
      else sh = 8 * int'(ea[1:0]);
      if (st) begin
        if (sz == 2'b00) nw = (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        else if (sz == 2'b01) nw = (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        else nw = d;
        ref_mem[widx] = nw;
      end else begin
        v = old >> sh;
        if (sz == 2'b00) begin
          v = v & 32'hFF;
          if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
          v = v & 32'hFFFF;
          if (sx && v[15]) v = v | 32'hFFFF0000;
        end
        exp_load = v;
      end
    end

    check({tag, ".latency"}, cyc, lat);
    check({tag, ".err"}, {31'b0, err}, {31'b0, er});
    check({tag, ".busy_at_done"}, {31'b0, busy}, 32'h0);
    check({tag, ".load_data"}, load_data, exp_load);
    check({tag, ".writes"}, n_writes - w0, (st && !er) ? 32'd1 : 32'd0);
    if (!er) check({tag, ".addr"}, {16'h0, data_address}, {16'h0, widx});
    if (st && !er) check({tag, ".mem"}, dut_mem[widx], ref_mem[widx]);
    $display("op %s: st=%0b size=%0d sx=%0b ea=%h err=%0b lat=%0d load_data=%h",
             tag, st, sz, sx, ea, er, cyc, load_data);
    if (hold) begin
      start = 1'b0;
      @(negedge clk);
      check({tag, ".no_queue_busy"}, {31'b0, busy}, 32'h0);
      check({tag, ".no_queue_done"}, {31'b0, done}, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    base = 32'h0; offset = 16'h0; store_data = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Word store then word load
    run_op("wstore_c", 1'b1, 2'b10, 1'b0, 32'h0, 16'h000C, 32'h88442211, 1'b0, 1'b0);
    run_op("wload_c",  1'b0, 2'b10, 1'b0, 32'h0, 16'h000C, 32'h0, 1'b0, 1'b0);
    // Byte loads with and without extension
    run_op("bload_d_s",  1'b0, 2'b00, 1'b1, 32'h0, 16'h000D, 32'h0, 1'b0, 1'b0);
    run_op("bload_f_s",  1'b0, 2'b00, 1'b1, 32'h0, 16'h000F, 32'h0, 1'b0, 1'b0);
    run_op("bload_f_z",  1'b0, 2'b00, 1'b0, 32'h0, 16'h000F, 32'h0, 1'b0, 1'b0);
    // Half store read-modify-write, then sign-extended half load
    run_op("hstore_e",   1'b1, 2'b01, 1'b0, 32'h0, 16'h000E, 32'h0000BEEF, 1'b0, 1'b0);
    run_op("hload_e_s",  1'b0, 2'b01, 1'b1, 32'h0, 16'h000E, 32'h0, 1'b0, 1'b0);
    // Error cases
    run_op("err_wmis",   1'b0, 2'b10, 1'b0, 32'h0, 16'h0006, 32'h0, 1'b0, 1'b0);
    run_op("err_hmis",   1'b1, 2'b01, 1'b0, 32'h0, 16'h0005, 32'h12345678, 1'b0, 1'b0);
    run_op("err_range",  1'b0, 2'b10, 1'b0, 32'h00040000, 16'h0000, 32'h0, 1'b0, 1'b0);
    run_op("err_rsvd",   1'b1, 2'b11, 1'b0, 32'h0, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0);
    // Back-to-back: start raised during the done cycle of the previous op
    run_op("b2b_load",   1'b0, 2'b10, 1'b0, 32'h0, 16'h000C, 32'h0, 1'b1, 1'b0);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; size = 2'b00; sign_ext = 1'b0;
    base = 32'h0; offset = 16'h000C; store_data = 32'h00000055;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_write.strobe", {31'b0, write_en}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("rst_write");
    check("rst_write.mem", dut_mem[3], ref_mem[3]);
    exp_load = 32'h0;
    rst_n = 1'b1;
    run_op("after_rst1", 1'b0, 2'b10, 1'b0, 32'h0, 16'h000C, 32'h0, 1'b0, 1'b0);

    // Reset one cycle after start of a word store
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; size = 2'b10;
    base = 32'h0; offset = 16'h000C; store_data = 32'hCAFEF00D;
    @(negedge clk); start = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("rst_addr");
    @(negedge clk);
    check("rst_addr.mem", dut_mem[3], ref_mem[3]);
    exp_load = 32'h0;
    rst_n = 1'b1;
    run_op("after_rst2", 1'b0, 2'b01, 1'b1, 32'h0, 16'h000E, 32'h0, 1'b0, 1'b0);

    // Negative offset with start held high through busy
    run_op("negoff_hold", 1'b1, 2'b10, 1'b0, 32'h20, 16'hFFF8, 32'hA5A5_5A5A, 1'b0, 1'b1);
    run_op("negoff_load", 1'b0, 2'b00, 1'b1, 32'h20, 16'hFFF9, 32'h0, 1'b0, 1'b0);

    // Randomized operations over a small address window
    for (int i = 0; i < 60; i++) begin
      logic [31:0] rb;
      logic [15:0] ro;
      rb = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 64));
      ro = 16'(int'($urandom_range(0, 40)) - 20);
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), rb, ro, $urandom,
             ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
